// File: rtl/imem_loader_pkg.sv
// Shared types and sizes for the instruction-memory loader.
package imem_loader_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned HDR_W          = 8;
    localparam int unsigned CNT_W          = $clog2(BYTES_PER_WORD);

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DATA,
        WRITE,
        CHK,
        DONE,
        ERR
    } state_e;

endpackage

// File: rtl/imem_loader_word_packer.sv
// Packs bytes MSB-first into words; word_o/full_o update together on the last byte
// so the assembled word is held stable while the next one is being shifted in.
module word_packer
    import imem_loader_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              shift_i,
    input  logic [BYTE_W-1:0] byte_i,
    output logic              last_c_o,
    output logic              full_o,
    output logic [DATA_W-1:0] word_o
);

    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] word_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              full_q;
    logic [DATA_W-1:0] shifted_c;

    assign shifted_c = {shift_q[DATA_W-BYTE_W-1:0], byte_i};
    assign last_c_o  = (cnt_q == CNT_W'(BYTES_PER_WORD - 1));
    assign full_o    = full_q;
    assign word_o    = word_q;

    // full_q is a one-cycle pulse in the cycle after the last byte of a word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
            word_q  <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
        end else begin
            full_q <= 1'b0;
            if (clear_i) begin
                shift_q <= '0;
                cnt_q   <= '0;
            end else if (shift_i) begin
                shift_q <= shifted_c;
                cnt_q   <= cnt_q + CNT_W'(1);
                if (last_c_o) begin
                    word_q <= shifted_c;
                    full_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Streams a header-prefixed byte image into instruction memory and releases the core when done.
// Optional trailing XOR checksum byte enabled by `define IMEM_LOADER_CHECKSUM_EN.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              rx_valid_i,
    input  logic [BYTE_W-1:0] rx_data_i,
    output logic              rx_ready_o,
    output logic              im_wren_o,
    output logic [ADDR_W-1:0] im_addr_o,
    output logic [DATA_W-1:0] im_data_o,
    output logic              cpu_enable_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o
);

    state_e             state_q;
    logic [HDR_W-1:0]   words_left_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [ADDR_W-1:0]  im_addr_q;
    logic               rx_ready_q;
    logic               cpu_enable_q;
    logic               busy_q;
    logic               done_q;
    logic               error_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0]  xor_q;
`endif

    logic               accept_c;
    logic               restart_c;
    logic               pack_shift_c;
    logic               pack_last_c;

    assign accept_c     = rx_valid_i && rx_ready_q;
    assign restart_c    = start_i && (state_q == IDLE || state_q == DONE || state_q == ERR);
    assign pack_shift_c = accept_c && (state_q == DATA);

    word_packer #(
        .DATA_W (DATA_W)
    ) u_packer (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (restart_c),
        .shift_i  (pack_shift_c),
        .byte_i   (rx_data_i),
        .last_c_o (pack_last_c),
        .full_o   (im_wren_o),
        .word_o   (im_data_o)
    );

    assign rx_ready_o   = rx_ready_q;
    assign im_addr_o    = im_addr_q;
    assign cpu_enable_o = cpu_enable_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign error_o      = error_q;

    // Load sequencer; rx_ready_q is set on every transition into a receive state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            words_left_q <= '0;
            addr_q       <= '0;
            im_addr_q    <= '0;
            rx_ready_q   <= 1'b0;
            cpu_enable_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q        <= '0;
`endif
        end else begin
            case (state_q)
                IDLE, DONE, ERR: begin
                    if (state_q == DONE) begin
                        cpu_enable_q <= 1'b1;
                    end
                    if (restart_c) begin
                        state_q      <= HDR;
                        rx_ready_q   <= 1'b1;
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
                        error_q      <= 1'b0;
                        cpu_enable_q <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        xor_q        <= '0;
`endif
                    end
                end
                HDR: begin
                    if (accept_c) begin
                        words_left_q <= rx_data_i;
                        addr_q       <= '0;
                        state_q      <= DATA;
                    end
                end
                DATA: begin
                    if (accept_c) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        xor_q <= xor_q ^ rx_data_i;
`endif
                        if (pack_last_c) begin
                            state_q    <= WRITE;
                            rx_ready_q <= 1'b0;
                            im_addr_q  <= addr_q;
                        end
                    end
                end
                WRITE: begin
                    // words_left bounds addr_q, so the top address is reached without wrapping
                    if (words_left_q == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_q    <= CHK;
                        rx_ready_q <= 1'b1;
`else
                        state_q    <= DONE;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
`endif
                    end else begin
                        addr_q       <= addr_q + ADDR_W'(1);
                        words_left_q <= words_left_q - HDR_W'(1);
                        state_q      <= DATA;
                        rx_ready_q   <= 1'b1;
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                CHK: begin
                    if (accept_c) begin
                        rx_ready_q <= 1'b0;
                        busy_q     <= 1'b0;
                        if (rx_data_i == xor_q) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ERR;
                            error_q <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    state_q    <= IDLE;
                    rx_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: images are generated here and expected IM writes
// and final status are derived from the stream format rules.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic        rx_valid_i = 1'b0;
    logic [7:0]  rx_data_i = 8'h00;
    logic        rx_ready_o;
    logic        im_wren_o;
    logic [7:0]  im_addr_o;
    logic [31:0] im_data_o;
    logic        cpu_enable_o;
    logic        busy_o;
    logic        done_o;
    logic        error_o;

    int total = 0;
    int bad   = 0;

    logic [39:0] exp_q[$];
    logic [31:0] img[256];
    int          wr_cnt = 0;
    logic [7:0]  last_addr = 8'h00;
    logic [31:0] last_data = 32'h0;
    logic [7:0]  prev_addr = 8'h00;
    logic [31:0] prev_data = 32'h0;

    always #5 clk = ~clk;

    imem_loader dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .rx_valid_i   (rx_valid_i),
        .rx_data_i    (rx_data_i),
        .rx_ready_o   (rx_ready_o),
        .im_wren_o    (im_wren_o),
        .im_addr_o    (im_addr_o),
        .im_data_o    (im_data_o),
        .cpu_enable_o (cpu_enable_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .error_o      (error_o)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Write-port monitor: every write must be the next one the image predicts
    always @(negedge clk) begin
        if (!rst) begin
            if (im_wren_o) begin
                wr_cnt++;
                last_addr = im_addr_o;
                last_data = im_data_o;
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 1, 0);
                end else begin
                    logic [39:0] e;
                    e = exp_q.pop_front();
                    chk("wr_addr", im_addr_o, e[39:32]);
                    chk("wr_data", im_data_o, e[31:0]);
                end
                chk("ready_in_write", rx_ready_o, 0);
            end else begin
                chk("addr_hold", im_addr_o, prev_addr);
                chk("data_hold", im_data_o, prev_data);
            end
            if (cpu_enable_o) chk("cpu_en_state", {busy_o, done_o, error_o}, 3'b010);
        end
        prev_addr = im_addr_o;
        prev_data = im_data_o;
    end

    task automatic send_byte(input logic [7:0] b, input bit jitter);
        int guard;
        while (jitter && $urandom_range(0, 2) == 0) begin
            rx_valid_i = 1'b0;
            rx_data_i  = 8'($urandom);
            tick();
        end
        rx_valid_i = 1'b1;
        rx_data_i  = b;
        guard = 0;
        while (!rx_ready_o && guard < 50) begin
            tick();
            guard++;
        end
        if (!rx_ready_o) chk("rx_ready_timeout", 0, 1);
        tick();
        rx_valid_i = 1'b0;
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    // chk_sel < 0 sends the correct checksum, otherwise that literal byte
    task automatic do_load(input int n, input bit jitter, input bit busy_start, input int chk_sel);
        logic [7:0]  x;
        logic [7:0]  b;
        logic [31:0] w;
        bit          ok;
        int          guard;
        x  = 8'h00;
        ok = 1'b1;
        pulse_start();
        send_byte(8'(n - 1), jitter);
        for (int k = 0; k < n; k++) begin
            w = img[k];
            exp_q.push_back({8'(k), w});
            for (int j = 3; j >= 0; j--) begin
                b = w[8*j +: 8];
                x ^= b;
                send_byte(b, jitter);
            end
            if (busy_start && k == 0) begin
                tick();
                pulse_start();
            end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        b  = (chk_sel < 0) ? x : 8'(chk_sel);
        ok = (b == x);
        send_byte(b, jitter);
`endif
        guard = 0;
        while (busy_o && guard < 40) begin
            tick();
            guard++;
        end
        chk("load_end_timeout", busy_o, 0);
        tick();
        tick();
        chk("done", done_o, ok);
        chk("error", error_o, !ok);
        chk("cpu_enable", cpu_enable_o, ok);
        chk("rx_ready_idle", rx_ready_o, 0);
        chk("pending_writes", exp_q.size(), 0);
    endtask

    initial begin
        int base;
        int guard;

        repeat (3) tick();
        rst = 1'b0;
        repeat (20) tick();
        chk("rst_rx_ready", rx_ready_o, 0);
        chk("rst_wren", im_wren_o, 0);
        chk("rst_addr", im_addr_o, 0);
        chk("rst_data", im_data_o, 0);
        chk("rst_cpu_en", cpu_enable_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_error", error_o, 0);

        // single word, hand-computed image and checksum (12^34^56^78 = 08)
        img[0] = 32'h12345678;
        do_load(1, 1'b0, 1'b0, 8);
        chk("t1_last_addr", last_addr, 8'h00);
        chk("t1_last_data", last_data, 32'h12345678);

        // bytes offered outside a receive state are not consumed
        base = wr_cnt;
        rx_valid_i = 1'b1;
        rx_data_i  = 8'hAA;
        repeat (5) begin
            tick();
            chk("ready_in_done", rx_ready_o, 0);
        end
        rx_valid_i = 1'b0;
        tick();
        chk("done_held", {done_o, cpu_enable_o, busy_o}, 3'b110);
        chk("no_write_in_done", wr_cnt - base, 0);

        // two words with ragged valid and an ignored mid-load start
        img[0] = $urandom;
        img[1] = $urandom;
        base = wr_cnt;
        do_load(2, 1'b1, 1'b1, -1);
        chk("h1_writes", wr_cnt - base, 2);

        for (int r = 0; r < 4; r++) begin
            int n;
            n = $urandom_range(1, 6);
            for (int k = 0; k < n; k++) img[k] = $urandom;
            base = wr_cnt;
            do_load(n, 1'($urandom_range(0, 1)), 1'b0, -1);
            chk("rand_writes", wr_cnt - base, n);
        end

        // full capacity ends exactly at the top address
        for (int k = 0; k < 256; k++) img[k] = $urandom;
        base = wr_cnt;
        do_load(256, 1'b0, 1'b0, -1);
        chk("full_writes", wr_cnt - base, 256);
        chk("full_last_addr", last_addr, 8'hFF);

`ifdef IMEM_LOADER_CHECKSUM_EN
        img[0] = 32'h01020304;
        do_load(1, 1'b0, 1'b0, 5);
        chk("bad_chk_error", error_o, 1);
        chk("bad_chk_cpu_en", cpu_enable_o, 0);
        img[0] = 32'hDEADBEEF;
        img[1] = 32'h00C0FFEE;
        do_load(2, 1'b1, 1'b0, -1);
        chk("recover_error", error_o, 0);
        chk("recover_done", done_o, 1);
`endif

        // reset partway through an H=3 load
        for (int k = 0; k < 4; k++) img[k] = $urandom;
        base = wr_cnt;
        pulse_start();
        send_byte(8'd3, 1'b0);
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back({8'(k), img[k]});
            for (int j = 3; j >= 0; j--) send_byte(img[k][8*j +: 8], 1'b0);
        end
        guard = 0;
        while (wr_cnt < base + 2 && guard < 10) begin
            tick();
            guard++;
        end
        chk("pre_rst_writes", wr_cnt - base, 2);
        #2 rst = 1'b1;
        #1;
        chk("arst_outputs", {rx_ready_o, im_wren_o, cpu_enable_o, busy_o, done_o, error_o}, 6'b0);
        chk("arst_addr", im_addr_o, 0);
        chk("arst_data", im_data_o, 0);
        repeat (2) tick();
        rst = 1'b0;
        tick();
        chk("post_rst_idle", {rx_ready_o, busy_o}, 2'b00);
        chk("post_rst_pending", exp_q.size(), 0);
        base = wr_cnt;
        do_load(4, 1'b1, 1'b0, -1);
        chk("post_rst_writes", wr_cnt - base, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
